// File: rtl/line_burst_ctrl_pkg.sv
// Shared cache-side constants and the burst sequencer state type.
// Imported by the line/burst controller and anything sizing cachelines.
package line_burst_ctrl_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = 4;
  localparam int OFFSET_W = 5;
  localparam int BEAT_CW  = $clog2(BEATS);

  // Clears the byte offset of a line address.
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } burst_state_t;

endpackage

// File: rtl/line_burst_ctrl.sv
// Splits one 256-bit line transaction into four 64-bit memory bursts
// and reassembles read beats back into a line.
// Ports:
//   clk, rst       : clock, async active-high reset
//   line_*         : arbiter side (address, rdata, wdata, read, write, resp)
//   burst_*        : memory side (address, rdata, wdata, read, write, resp)
module line_burst_ctrl
  import line_burst_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         line_address,
  output logic [LINE_W-1:0]   line_rdata,
  input  logic [LINE_W-1:0]   line_wdata,
  input  logic                line_read,
  input  logic                line_write,
  output logic                line_resp,
  output logic [31:0]         burst_address,
  input  logic [BEAT_W-1:0]   burst_rdata,
  output logic [BEAT_W-1:0]   burst_wdata,
  output logic                burst_read,
  output logic                burst_write,
  input  logic                burst_resp
);

  burst_state_t r_state;
  burst_state_t w_next;

  logic [BEAT_CW-1:0] r_beat;
  logic [LINE_W-1:0]  r_buf;
  logic [31:0]        r_addr;

  logic w_acc_wr;
  logic w_acc_rd;
  logic w_last;
  logic w_step;

  // Write wins if both requests arrive together.
  assign w_acc_wr = (r_state == IDLE) && line_write;
  assign w_acc_rd = (r_state == IDLE) && line_read && !line_write;
  assign w_last   = (r_beat == BEAT_CW'(BEATS - 1));
  assign w_step   = ((r_state == RD) || (r_state == WR)) && burst_resp;

  always_comb begin
    w_next      = r_state;
    line_resp   = 1'b0;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_acc_wr)      w_next = WR;
        else if (w_acc_rd) w_next = RD;
      end
      RD: begin
        burst_read = 1'b1;
        if (burst_resp && w_last) w_next = DONE;
      end
      WR: begin
        burst_write = 1'b1;
        if (burst_resp && w_last) w_next = DONE;
      end
      DONE: begin
        line_resp = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc_wr || w_acc_rd) begin
        r_addr <= line_address & LINE_MASK;
        r_beat <= '0;
      end
      if (w_acc_wr)
        r_buf <= line_wdata;
      // Counter wraps to 0 on the last beat, ready for the next line.
      if (w_step)
        r_beat <= r_beat + 1'b1;
      if (w_step && (r_state == RD))
        r_buf[r_beat*BEAT_W +: BEAT_W] <= burst_rdata;
    end
  end

  assign line_rdata    = r_buf;
  assign burst_address = r_addr;
  assign burst_wdata   = r_buf[r_beat*BEAT_W +: BEAT_W];

endmodule
